// File: rtl/vga_sprite_compositor.sv
// vga_sprite_compositor: VGA timing with a pixel-enable divider, a scrolling
// 1-bit background and NUM_SPRITES 1-bit sprite layers, one pixel of latency.
module vga_sprite_compositor #(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter int          CLK_DIV     = 4,
    parameter int          NUM_SPRITES = 2,
    parameter int          SPR_W       = 65,
    parameter int          SPR_H       = 65,
    parameter int          SCROLL_STEP = 1,
    parameter logic [11:0] FG_COLOR    = 12'h000,
    parameter logic [11:0] BG_COLOR    = 12'hfff,
    parameter int          SA_W        = $clog2(SPR_W * SPR_H),
    parameter int          BA_W        = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SPRITES*10-1:0]   pos_x,
    input  logic [NUM_SPRITES*9-1:0]    pos_y,
    input  logic [NUM_SPRITES-1:0]      spr_en,
    input  logic                        scroll_en,
    output logic [BA_W-1:0]             bg_addr,
    input  logic                        bg_data,
    output logic [NUM_SPRITES*SA_W-1:0] spr_addr,
    input  logic [NUM_SPRITES-1:0]      spr_data,
    output logic                        hSync,
    output logic                        vSync,
    output logic [3:0]                  VGA_R,
    output logic [3:0]                  VGA_G,
    output logic [3:0]                  VGA_B,
    output logic                        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int DV_W    = $clog2(CLK_DIV);
    localparam int SC_W    = $clog2(H_ACTIVE);
    localparam int XS_W    = HC_W + 1;
    localparam int HS_LO   = H_ACTIVE + H_FP;
    localparam int HS_HI   = HS_LO + H_SYNC;
    localparam int VS_LO   = V_ACTIVE + V_FP;
    localparam int VS_HI   = VS_LO + V_SYNC;
    localparam int STEP_M  = SCROLL_STEP % H_ACTIVE;

    logic [DV_W-1:0]           div;
    logic                      pix_en;
    logic [HC_W-1:0]           hc;
    logic [VC_W-1:0]           vc;
    logic                      h_last;
    logic                      v_last;
    logic                      boundary;

    logic [NUM_SPRITES*10-1:0] sh_x;
    logic [NUM_SPRITES*9-1:0]  sh_y;
    logic [NUM_SPRITES-1:0]    sh_en;
    logic [SC_W-1:0]           scroll;
    logic [SC_W:0]             scroll_sum;
    logic [SC_W-1:0]           scroll_nxt;

    logic                      active;
    logic [XS_W-1:0]           xs;
    logic [XS_W-1:0]           xw;
    logic [NUM_SPRITES-1:0]    hit;
    logic                      fg;
    logic [11:0]               color0;
    logic [11:0]               color_q;
    logic                      hs0;
    logic                      vs0;
    logic [HC_W:0]             hc_x;
    logic [VC_W:0]             vc_x;

    // ---------------------------------------------------------------
    // Pixel-enable divider
    // ---------------------------------------------------------------
    assign pix_en = (div == DV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (pix_en) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Raster counters
    // ---------------------------------------------------------------
    assign h_last   = (hc == HC_W'(H_TOTAL - 1));
    assign v_last   = (vc == VC_W'(V_TOTAL - 1));
    assign boundary = pix_en && h_last && (vc == VC_W'(V_ACTIVE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                hc <= '0;
                vc <= v_last ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Frame-boundary shadows and scroll
    // ---------------------------------------------------------------
    assign scroll_sum = {1'b0, scroll} + (SC_W + 1)'(STEP_M);
    assign scroll_nxt = (scroll_sum >= (SC_W + 1)'(H_ACTIVE))
                      ? SC_W'(scroll_sum - (SC_W + 1)'(H_ACTIVE))
                      : SC_W'(scroll_sum);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_x        <= '0;
            sh_y        <= '0;
            sh_en       <= '0;
            scroll      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
            if (boundary) begin
                sh_x  <= pos_x;
                sh_y  <= pos_y;
                sh_en <= spr_en;
                if (scroll_en) begin
                    scroll <= scroll_nxt;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 0: addresses and hits from counters and shadows
    // ---------------------------------------------------------------
    assign active = (hc < HC_W'(H_ACTIVE)) && (vc < VC_W'(V_ACTIVE));

    assign xs = XS_W'(hc) + XS_W'(scroll);
    assign xw = (xs >= XS_W'(H_ACTIVE)) ? xs - XS_W'(H_ACTIVE) : xs;

    assign bg_addr = active
                   ? BA_W'(BA_W'(vc) * BA_W'(H_ACTIVE) + BA_W'(xw))
                   : '0;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
        logic [10:0] sx;
        logic [10:0] sy;
        logic [10:0] hx;
        logic [10:0] vy;
        logic [10:0] dx;
        logic [10:0] dy;
        logic        in_x;
        logic        in_y;

        // 11-bit compares keep sx+SPR_W from wrapping near the 10-bit limit
        assign sx   = {1'b0, sh_x[10*i +: 10]};
        assign sy   = {2'b00, sh_y[9*i +: 9]};
        assign hx   = 11'(hc);
        assign vy   = 11'(vc);
        assign dx   = hx - sx;
        assign dy   = vy - sy;
        assign in_x = (hx >= sx) && (hx < sx + 11'(SPR_W));
        assign in_y = (vy >= sy) && (vy < sy + 11'(SPR_H));

        assign hit[i] = active && sh_en[i] && in_x && in_y;

        assign spr_addr[SA_W*i +: SA_W] = hit[i]
            ? SA_W'(SA_W'(dy) * SA_W'(SPR_W) + SA_W'(dx))
            : '0;
    end

    // ---------------------------------------------------------------
    // Composite and stage 1 registers
    // ---------------------------------------------------------------
    // Every sprite draws FG_COLOR, so the lowest-index winner reduces to an OR
    assign fg = |(hit & spr_data);

    always_comb begin
        color0 = 12'h000;
        if (active) begin
            color0 = (fg || bg_data) ? FG_COLOR : BG_COLOR;
        end
    end

    assign hc_x = {1'b0, hc};
    assign vc_x = {1'b0, vc};
    assign hs0  = !((hc_x >= (HC_W + 1)'(HS_LO)) && (hc_x < (HC_W + 1)'(HS_HI)));
    assign vs0  = !((vc_x >= (VC_W + 1)'(VS_LO)) && (vc_x < (VC_W + 1)'(VS_HI)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hSync   <= 1'b1;
            vSync   <= 1'b1;
            color_q <= 12'h000;
        end else if (pix_en) begin
            hSync   <= hs0;
            vSync   <= vs0;
            color_q <= color0;
        end
    end

    assign VGA_R = color_q[11:8];
    assign VGA_G = color_q[7:4];
    assign VGA_B = color_q[3:0];

endmodule

// File: doc/vga_sprite_compositor.md
# vga_sprite_compositor

Parametrised VGA pixel pipeline that replaces the single-sprite, fixed-640×480 controller. It generates VGA timing from the 100 MHz system clock through an internal pixel-enable divider. It composites up to NUM_SPRITES 1-bit sprites over a horizontally scrolling 1-bit background and drives hSync/vSync/RGB. Sprite positions are latched once per frame, and sprite addresses are computed from pixel coordinates rather than a free-running offset.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- CLK_DIV, 4, clk cycles per pixel; must be ≥2
- NUM_SPRITES, 2, sprite layers, 1..8
- SPR_W / SPR_H, 65 / 65, sprite size in pixels
- SCROLL_STEP, 1, background pixels scrolled per frame
- FG_COLOR / BG_COLOR, 12'h000 / 12'hfff, colour for a set bit / a clear bit
- SA_W, $clog2(SPR_W*SPR_H), sprite address width
- BA_W, $clog2(H_ACTIVE*V_ACTIVE), background address width

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high
- pos_x  in  NUM_SPRITES*10  sprite left edges, sprite i at [10i+9:10i]
- pos_y  in  NUM_SPRITES*9  sprite top edges
- spr_en  in  NUM_SPRITES  per-sprite enable
- scroll_en  in  1  advance background scroll at each frame boundary
- bg_addr  out  BA_W  background RAM read address
- bg_data  in  1  background RAM data; 1-clk synchronous read latency
- spr_addr  out  NUM_SPRITES*SA_W  per-sprite RAM read address
- spr_data  in  NUM_SPRITES  sprite RAM data; 1-clk latency
- hSync, vSync  out  1  sync outputs, active-low
- VGA_R, VGA_G, VGA_B  out  4 each  colour outputs
- frame_start  out  1  one-clk pulse at the frame boundary

## Operation
- Divider:
  - Counts 0..CLK_DIV-1.
  - pix_en is high for one clk when the count is CLK_DIV-1.
  - All pixel-domain state advances only on pix_en.
- Counters:
  - hc runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - vc increments when hc wraps and itself wraps at V_TOTAL.
  - active = hc<H_ACTIVE && vc<V_ACTIVE.
  - Sync is low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vSync uses the same rule on vc.
- Frame boundary: the pix_en at which the counters move to (hc=0, vc=V_ACTIVE). On that pix_en:
  - pos_x, pos_y and spr_en are latched into shadow registers.
  - If scroll_en, scroll ← (scroll+SCROLL_STEP) mod H_ACTIVE.
  - frame_start pulses for that clk.
- Stage 0 (combinational from counters and shadows):
  - bg_addr = vc*H_ACTIVE + ((hc+scroll) mod H_ACTIVE), or 0 when not active.
  - Sprite i hits when hc∈[sx_i, sx_i+SPR_W), vc∈[sy_i, sy_i+SPR_H) and en_i. Compare in 11 bits so sx+SPR_W never wraps.
  - Sprites partly off the right or bottom edge are clipped naturally.
  - spr_addr_i = (vc-sy_i)*SPR_W + (hc-sx_i) on a hit, else 0.
- Stage 1:
  - On the next pix_en, register the colour, hSync, vSync and active from the stage-0 values of the previous pixel.
  - RAM data has settled by then, since CLK_DIV≥2.
- Composite:
  - The lowest-index sprite with hit && spr_data wins and gives FG_COLOR.
  - Otherwise the pixel is bg_data ? FG_COLOR : BG_COLOR.
  - Non-active pixels output 12'h000.

## Timing
- Reset values: divider, hc, vc and scroll are 0. Shadows are 0 with spr_en shadow 0. hSync=vSync=1, RGB=0, frame_start=0.
- The first pix_en after reset deassertion occurs CLK_DIV clks later.
- Pipeline latency:
  - Outputs lag the counters by exactly one pixel period (CLK_DIV clks).
  - Sync and colour stay mutually aligned.
- Position changes mid-frame have no effect until the next frame boundary, so there is no tearing.
- If pos and scroll_en change in the same clk as the boundary pix_en, the new values are taken.
- Overlapping sprites: lower index has priority.
- A sprite with sx ≥ H_ACTIVE never hits an active pixel.
- Reset asserted mid-line forces all outputs to their reset values immediately (asynchronous).
- Scroll wraps at H_ACTIVE and is never ≥ H_ACTIVE.

## Test plan
- Sync timing: run 2 frames with reset=0 and default parameters.
  - hSync low for 96 pixels (384 clks) every 800 pixels.
  - vSync low for 2 lines every 525 lines.
  - frame_start pulses once per 420000 pixels.
- Sprite address: sprite0 at (30,270), enabled, spr_data=1.
  - At pixel (30,270) spr_addr0=0.
  - At (94,334) spr_addr0=4224.
  - RGB=000 exactly one pixel later; at (95,270) no hit.
- Priority and mid-frame latch: sprites 0 and 1 both at (100,100). Sprite1 data=1, sprite0 data=0 → FG.
  - Change pos_x0 to 200 mid-frame → the first frame still shows (100,100).
  - The frame after the boundary shows 200.
- Scroll: scroll_en=1 for 641 frames.
  - bg_addr at (0,0) equals frame count mod 640, returning to 1 after the wrap.
- Edge clipping and reset: sprite at (600,450).
  - Hits stop at hc=639 and vc=479.
  - Assert reset mid-line → hSync=vSync=1, RGB=0 in the same clk.
  - Counters resume from (0,0) after release.
